// File: rtl/onehot_rr_arbiter.sv
// 16-way round-robin arbiter driving a 16-to-4 encoder: registered one-hot grant with a forced idle gap.
// Optional hold-limit timeout built when ONEHOT_ARB_TIMEOUT_EN is defined; release_grant carries the owner's release (release is a reserved word).
module onehot_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] req,
  input  logic        release_grant,
  output logic [15:0] grant_out,
  output logic        grant_valid,
  output logic        timeout
);

  // state | meaning
  // IDLE  | no grant; arbitrate from ptr when req is non-zero
  // GRANT | one-hot grant held until release, withdraw or hold limit
  // GAP   | one all-zero cycle so the encoder never hops between owners
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] grant_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        timeout_d;
  logic        hold_hit;
  logic        withdrawn;
  logic        pick_found;
  logic [3:0]  pick_idx;
  logic [3:0]  scan_idx;

  // Rotating priority search: first set bit at or above ptr, wrapping 15 -> 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int i = 0; i < 16; i++) begin
      scan_idx = ptr_q + 4'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign withdrawn = ~|(req & grant_out);

`ifdef ONEHOT_ARB_TIMEOUT_EN
  logic [7:0] hold_q;

  assign hold_hit = (hold_q == 8'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              hold_q <= '0;
    else if (state_q == GRANT) hold_q <= hold_q + 8'd1;
    else                       hold_q <= '0;
  end
`else
  logic unused_max_hold;

  assign hold_hit        = 1'b0;
  assign unused_max_hold = ^8'(MAX_HOLD);
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_out;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          grant_d = 16'h0001 << pick_idx;
          ptr_d   = pick_idx + 4'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_grant || withdrawn) begin
          grant_d = '0;
          state_d = GAP;
        end else if (hold_hit) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = GAP;
        end
      end
      GAP: begin
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_out   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_out   <= grant_d;
      grant_valid <= |grant_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: doc/onehot_rr_arbiter.md
# onehot_rr_arbiter

- Round-robin arbiter for 16 requesters.
- Issues a registered one-hot grant vector plus a grant-valid strobe.
- These feed the downstream 16-to-4 encoder directly: `grant_out` drives `encoder_in` and `grant_valid` drives `enable`.
- It guarantees that the encoder only ever sees an all-zero vector or exactly one set bit. It also inserts an idle gap between grants, so the encoded index never switches directly from one requester to another.

## Interface
- `MAX_HOLD`, default 8: maximum number of cycles a single grant may be held. Legal range 2–255.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset; one clock.
- `req`  in  16  request vector; bit i = requester i wants the resource.
- `release`  in  1  current grant owner signals completion. Only meaningful in GRANT.
- `grant_out`  out  16  registered one-hot grant vector; all zeros when no grant.
- `grant_valid`  out  1  high exactly when `grant_out` is non-zero.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine: IDLE, GRANT, GAP. Reset state is IDLE.
- Reset values: `grant_out`=16'h0000, `grant_valid`=0, `timeout`=0, pointer `ptr`=0, hold counter=0.
- **IDLE**
  - If `req` == 0: stay in IDLE.
  - Otherwise, select the first set bit of `req` scanning upward from `ptr`, wrapping 15→0.
  - Load the one-hot grant for the selected bit, set `ptr` = (index+1) mod 16 (15 wraps to 0), clear the hold counter, go to GRANT.
- **GRANT**
  - `grant_out`/`grant_valid` are held stable.
  - The hold counter increments every cycle.
  - Exit to GAP on the first of these events:
    - `release`=1;
    - `req[granted]`=0 (the requester withdraws);
    - the hold counter reaches `MAX_HOLD`-1. This is the timeout case, and it also asserts `timeout` for one cycle.
  - Exit priority: release > withdraw > timeout. `timeout` pulses only when neither release nor withdraw is present in that cycle.
- **GAP**: `grant_out`=0 and `grant_valid`=0 for exactly one cycle, then go to IDLE. `req` is ignored in GAP.
- `release` is ignored in IDLE and GAP.
- Changes to `req` bits other than the granted bit during GRANT have no effect on the current grant.
- Fairness: a continuously asserting requester is granted at most 15 grants after its request is first seen, because the pointer advances past each winner.
- An asynchronous reset in any state forces all outputs and state to their reset values immediately. The first arbitration after deassertion starts from `ptr`=0.

## Timing
- All outputs are registered and change only on a rising `clk` edge (or on reset).
- Grant latency: when `req` is sampled non-zero in IDLE at edge t, `grant_out` and `grant_valid` are valid after edge t.
- Release latency: when `release` is sampled at edge t, the outputs are zero after edge t.
- `timeout` is high during the same cycle that `grant_out` first reads zero.
- Minimum grant length is 1 cycle. Maximum is `MAX_HOLD` cycles when timeout is compiled in.
- Minimum spacing between two grants: 1 GAP cycle + 1 IDLE cycle. Back-to-back grants therefore appear on a 3-cycle cadence when each owner releases immediately.

## Configuration
- Macro: `ONEHOT_ARB_TIMEOUT_EN`.
- **Defined**: the hold counter, the `MAX_HOLD` limit and the `timeout` pulse are implemented exactly as described above.
- **Undefined**:
  - No hold counter is built and `timeout` is tied to 0.
  - A grant persists until `release` or withdraw.
  - `MAX_HOLD` is accepted but unused.

## Test plan
- **Reset and first grant**: hold reset, then release with `req`=16'h0000 → all outputs 0 and the block stays in IDLE. Then set `req`=16'h0005 → after 1 edge `grant_out`=16'h0001, `grant_valid`=1.
- **Round-robin rotation**:
  - Hold `req`=16'h8001 and pulse `release` each grant.
  - Grants alternate 16'h0001, 16'h8000, 16'h0001, separated by zero cycles.
  - `ptr` wraps 15→0 after the 16'h8000 grant.
- **Withdraw versus release in the same cycle**: while granted 16'h0010, drop `req[4]` and assert `release` together → exit via release, `timeout`=0, one GAP cycle with `grant_out`=0.
- **Timeout (macro defined, `MAX_HOLD`=4)**: hold `req`=16'h0100 with no `release` → `grant_out`=16'h0100 for 4 cycles, then 0 with `timeout`=1 for one cycle. With the macro undefined, the grant holds for more than 20 cycles and `timeout` stays 0.
- **Reset mid-grant**: assert `reset_n`=0 asynchronously while granted 16'h2000 → `grant_out`=0 and `grant_valid`=0 before the next edge. After deassertion with `req`=16'h2001, the next grant is 16'h0001.
- **Encoder compatibility**: apply random `req` for 10k cycles → `grant_out` is always zero or one-hot, `grant_valid` equals (`grant_out` != 0), and at least one zero cycle separates any two distinct non-zero values.
